// File: rtl/tpu_pkg.sv
// Shared TPU constants and vector types.
// Imported by memA, memB and systolic_array.
package tpu_pkg;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;

  typedef logic [DIM-1:0][BITS_AB-1:0] opvec_t;
  typedef logic [DIM-1:0][BITS_C-1:0]  accvec_t;

endpackage

// File: rtl/mac_cell.sv
// One systolic MAC cell: Areg/Breg pass-through, Creg accumulator.
// Ports: en_i shift+accumulate, wr_en_i load c_i, a/b in->out, c_o acc.
module mac_cell #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               wr_en_i,
  input  logic [BITS_C-1:0]  c_i,
  input  logic [BITS_AB-1:0] a_i,
  input  logic [BITS_AB-1:0] b_i,
  output logic [BITS_AB-1:0] a_o,
  output logic [BITS_AB-1:0] b_o,
  output logic [BITS_C-1:0]  c_o
);

  logic [BITS_AB-1:0] a_q, b_q;
  logic [BITS_C-1:0]  c_q, c_d;
  logic signed [2*BITS_AB-1:0] prod;
  logic [BITS_C-1:0]  prod_x;

  assign prod = $signed(a_i) * $signed(b_i);
  // Signed size cast: sign-extends or truncates to BITS_C
  assign prod_x = BITS_C'(prod);

  always_comb begin
    c_d = c_q;
    if (wr_en_i)   c_d = c_i;
    else if (en_i) c_d = c_q + prod_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (en_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      c_q <= c_d;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;
  assign c_o = c_q;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary systolic MAC array.
// Ports: A/B skewed operands, en advance, WrEn/Crow/Cin row load, Cout row read.
module systolic_array #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int BITS_C  = tpu_pkg::BITS_C,
  parameter int DIM     = tpu_pkg::DIM,
  localparam int CW     = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          WrEn,
  input  logic [DIM-1:0][BITS_AB-1:0]   A,
  input  logic [DIM-1:0][BITS_AB-1:0]   B,
  input  logic [CW-1:0]                 Crow,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic [DIM-1:0][BITS_C-1:0]    Cout
);

  import tpu_pkg::*;

  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] a_out, b_out;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] a_in, b_in;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  c_out;
  logic [DIM-1:0]                       row_wr;

  for (genvar r = 0; r < DIM; r++) begin : g_row
    assign row_wr[r] = WrEn && (Crow == CW'(r));
    for (genvar c = 0; c < DIM; c++) begin : g_col
      if (c == 0) begin : g_a0
        assign a_in[r][c] = A[r];
      end else begin : g_an
        assign a_in[r][c] = a_out[r][c-1];
      end
      if (r == 0) begin : g_b0
        assign b_in[r][c] = B[c];
      end else begin : g_bn
        assign b_in[r][c] = b_out[r-1][c];
      end
      mac_cell #(
        .BITS_AB(BITS_AB),
        .BITS_C (BITS_C)
      ) u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en),
        .wr_en_i(row_wr[r]),
        .c_i    (Cin[c]),
        .a_i    (a_in[r][c]),
        .b_i    (b_in[r][c]),
        .a_o    (a_out[r][c]),
        .b_o    (b_out[r][c]),
        .c_o    (c_out[r][c])
      );
    end
  end

  // Out-of-range Crow (non-power-of-two DIM) matches no row -> zeros
  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++) begin
      if (Crow == CW'(r)) Cout = c_out[r];
    end
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- DIM x DIM output-stationary systolic multiply-accumulate array.
- Sits directly downstream of memA/memB:
  - consumes the skewed row stream memA presents on Aout;
  - consumes the skewed column stream memB presents on Bout.
- Accumulates C = A x B in per-cell registers.
- Each row of C is writable (preload or clear) and readable through a row-select port.

Parameters:
- BITS_AB, 8, signed width of A and B operands.
- BITS_C, 16, signed width of accumulators and C ports.
- DIM, 8, array dimension (rows = columns).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  advance: shift operands one cell and accumulate.
- WrEn  input  1  load Cin into accumulator row Crow.
- A  input  [DIM-1:0] x BITS_AB signed  A[r] enters cell (r,0); driven by memA Aout.
- B  input  [DIM-1:0] x BITS_AB signed  B[c] enters cell (0,c); driven by memB Bout.
- Crow  input  $clog2(DIM)  accumulator row selected for write and read.
- Cin  input  [DIM-1:0] x BITS_C signed  write data for row Crow, column c.
- Cout  output  [DIM-1:0] x BITS_C signed  accumulators of row Crow.

Behaviour:
- Cell (r,c) holds three registers: Areg, Breg, Creg.
- Operand sources:
  - Cell A input: A[r] when c=0, else Areg of (r,c-1).
  - Cell B input: B[c] when r=0, else Breg of (r-1,c).
- Reset: rst_n low asynchronously clears every Areg, Breg and Creg to 0.
  - Cout is therefore 0 during reset.
  - Reset mid-computation discards all partial sums and in-flight operands; no state survives.
- en=1 at a rising edge:
  - Areg <= A input.
  - Breg <= B input.
  - Creg <= Creg + (A input * B input).
- Arithmetic:
  - Product is a full 2*BITS_AB signed result, sign-extended (or truncated if BITS_C < 2*BITS_AB) to BITS_C.
  - Sum wraps modulo 2^BITS_C, two's complement; no saturation, no overflow flag.
- en=0: all registers hold.
- WrEn=1: Creg of every cell in row Crow <= Cin[c].
  - WrEn has priority over accumulation for that row only.
  - Areg and Breg of row Crow still shift if en=1.
  - Other rows accumulate normally when en=1.
- Cout[c] = Creg of cell (Crow,c).
  - Combinational read, zero latency.
  - Reflects the pre-edge value in the write cycle.
- Crow is always in range because DIM is a power of two. For non-power-of-two DIM, Crow >= DIM makes:
  - the write a no-op;
  - Cout all zeros.
- Timing with the memA/memB skew (row r delayed r cycles, column c delayed c cycles):
  - Operand pair k reaches cell (r,c) in en-cycle k+r+c.
  - Cell (r,c) is final after en-cycle DIM-1+r+c.
  - The full product is complete after 3*DIM-2 consecutive en cycles from the first valid operand.
- Upstream drives zeros in the skew bubbles, so extra en cycles beyond 3*DIM-2 add 0.

Decomposition:
- Shared package tpu_pkg holds:
  - default BITS_AB, BITS_C, DIM constants;
  - typedefs for the operand vector (DIM x BITS_AB signed) and accumulator vector (DIM x BITS_C signed).
- memA, memB and systolic_array all import tpu_pkg.
- One sub-module mac_cell (single Areg/Breg/Creg with en, WrEn, Cin, Aout, Bout, Cout).
- systolic_array instantiates the mac_cell grid in a generate loop and muxes the Crow row.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with nonzero accumulators -> Cout immediately 0 for every Crow; remains 0 after release until en.
- Identity: A = I (DIM=8), B[i][j] = i*8+j, skew-fed for 22 en cycles -> for each Crow=r, Cout[c] == r*8+c.
- Signed/wrap: all A=-128, all B=-128, 22 cycles -> every Creg = 8*16384 mod 65536 = 0. Same with A=127, B=-1 -> every Creg = -1016.
- Clear/preload: WrEn=1, Crow=3, Cin all 100, en=0 -> row 3 reads 100, other rows unchanged. Then one en cycle with A=B=0 -> row 3 still 100.
- Simultaneous: WrEn=1 on row 2 with en=1 and A[2]=5, B all 1 -> row 2 Creg = Cin (no +5); row 2 Areg still shifts 5 into cell (2,0).
- Hold: drop en for 5 cycles mid-stream, then resume -> final C identical to an uninterrupted run.
